serial_adder_seq: RTL
=====================

Name: serial_adder_seq

Overview:
- Bit-serial multi-bit adder sequencer built around the team's combinational 1-bit full adder.
- Latches two WIDTH-bit operands and presents one bit pair per cycle, LSB first, plus the stored carry, to the external full adder (fa_* ports).
- Captures the adder's sum/carry each cycle and delivers the registered WIDTH-bit result with a one-cycle done pulse.
- Sits directly upstream and downstream of the full-adder stage: it both feeds it and consumes its outputs.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); counter width = clog2(WIDTH+1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; honoured only in IDLE
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
cin  input  1  carry-in, sampled on the accepting edge
fa_a  output  1  bit to full adder input A (current LSB of A shift reg)
fa_b  output  1  bit to full adder input B (current LSB of B shift reg)
fa_cin  output  1  carry to full adder (carry register)
fa_sum  input  1  sum bit returned by full adder
fa_cout  input  1  carry returned by full adder
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered final carry, held until the next completion

Behaviour:
- Interface decided: one clock (clk), synchronous active-high reset (rst). All outputs are registered or decoded from registers.
- Reset (any state, incl. mid-operation): state=IDLE, busy=0, done=0, sum=0, cout=0, shift regs/carry/counter=0, fa_a=fa_b=fa_cin=0. A reset mid-operation produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - fa_a/fa_b/fa_cin forced 0.
  - On an edge with start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=SHIFT.
- SHIFT:
  - busy=1. fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
  - Each edge: a_sh/b_sh shift right (MSB fill 0); s_sh<={fa_sum, s_sh[WIDTH-1:1]}; carry<=fa_cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={fa_sum, s_sh[WIDTH-1:1]}, cout<=fa_cout, state<=DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0; fa_* forced 0.
  - Next edge: state<=IDLE unconditionally. start in DONE is ignored.
- Latency: start accepted at edge E0; bits 0..WIDTH-1 processed at edges E1..E_WIDTH; done high in the cycle after E_WIDTH (WIDTH+1 edges after acceptance). Minimum issue interval WIDTH+2 cycles.
- start while busy or in DONE: ignored; operands are not resampled and the in-flight result is unaffected.
- a/b/cin changes after acceptance: no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); wrap-around appears only in cout.
- sum/cout are not modified during SHIFT. They keep the previous result until the DONE entry edge.
- Full adder assumed purely combinational, same-cycle: fa_sum/fa_cout must be valid before the edge following the fa_* drive.

Test Plan:
- WIDTH=8, bench full adder: start, a=0x0F, b=0x01, cin=0 -> busy for 8 cycles, done 9 edges after acceptance, sum=0x10, cout=0; fa_a sequence 1,1,1,1,0,0,0,0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; fa_cin sequence 0,1,1,1,1,1,1,1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0 (previous result held until the second done).
- Accept a=0x12, b=0x34; pulse start with a=0xAA, b=0xAA at SHIFT cycle 3 and in the DONE cycle -> single done, sum=0x46, cout=0, no second operation begins.
- Accept a=0x55, b=0x55; assert rst at SHIFT cycle 4 -> next cycle all outputs 0, no done; new start a=0x01, b=0x02 -> sum=0x03 after 9 edges.
- WIDTH=4: a=0xF, b=0xF, cin=0 -> done after 5 edges, sum=0xE, cout=1; randomised 1000 operations vs. a+b+cin.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: streams two latched operands LSB first through an
// external combinational full adder and collects the result, one bit per cycle.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // Result registers only change on the last bit, so the previous
        // result stays visible for the whole operation.
        if (cnt_q == LAST) begin
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign fa_a   = busy & a_sh_q[0];
  assign fa_b   = busy & b_sh_q[0];
  assign fa_cin = busy & carry_q;
  assign sum    = sum_q;
  assign cout   = cout_q;

endmodule
